i2c_reg_bank: RTL and testbench
===============================

# i2c_reg_bank

Parametrised configuration/status register bank behind the I2C slave byte interface, successor to the fixed 13-register config file. Holds NUM_CFG staged (shadow) config registers that reach the core only on an explicit or automatic commit. Also holds NUM_STAT sticky status registers, cleared on read, plus a write-protect lock and a saturating error counter. Sits between the I2C slave (addr/dataIn/writeEn/readEn/dataOut) and the TDC core configuration and status nets.

## Interface
Parameters:
- NUM_CFG, 13, number of config registers, mapped at 0x01..NUM_CFG; 1..0x3F.
- NUM_STAT, 4, number of sticky status registers, mapped at STAT_BASE..STAT_BASE+NUM_STAT-1.
- STAT_BASE, 8'h40, first status address; requires NUM_CFG < STAT_BASE and STAT_BASE+NUM_STAT <= 8'h7E.
- DATA_W, 8, register width.
- ADDR_W, 8, address width.
- ID_VALUE, 8'h66, value returned at 0x00.
- CFG_RST, all zeros, NUM_CFG*DATA_W flattened reset value; register k occupies bits [k*DATA_W +: DATA_W], with k = address-1.

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- addr  in  ADDR_W  register address from the I2C slave.
- dataIn  in  DATA_W  write data.
- writeEn  in  1  one-cycle write strobe.
- readEn  in  1  one-cycle strobe issued when the slave consumes the read byte.
- dataOut  out  DATA_W  registered read data.
- cfg_o  out  NUM_CFG*DATA_W  active (committed) config, same packing as CFG_RST.
- cfg_upd_o  out  1  one-cycle pulse after the active config changes.
- stat_i  in  NUM_STAT*DATA_W  status event bits; level, sampled every cycle.
- locked_o  out  1  config write-protect active.

## Operation
- Address map:
  - 0x00 ID, read-only.
  - Config registers: read/write. Reads return the shadow value.
  - Status registers: read, clear-on-read.
  - 0x7E ERR: 8-bit saturating error count. Read returns the count; a write of any value clears it.
  - 0x7F CTRL: bit0 COMMIT (write-1 pulse, reads 0), bit1 LOCK, bit2 AUTO. Bits 7:3 read 0.
- Config write: shadow[addr] <= dataIn.
  - AUTO=0: cfg_o is unchanged until a write to CTRL with bit0=1 copies all shadows to cfg_o.
  - AUTO=1: shadow and active copy of that register update on the same edge.
- LOCK: set by a CTRL write with bit1=1 and cleared only by rst. While locked:
  - Config writes are dropped.
  - CTRL bit1/bit2 are frozen.
  - COMMIT is still honoured.
- Error counter increments, saturating at 0xFF, for any dropped or illegal write:
  - write to 0x00 or to a status address;
  - write to an unmapped address;
  - config write while locked.
  - A CTRL write while locked is not an error.
- Sticky status: sticky <= (sticky & ~clr) | stat_i every cycle. clr = all ones for register a when readEn=1 and addr=a, else 0. A set in the same cycle as the clear wins.
- Unmapped reads return 0.

## Timing
- Reset values:
  - dataOut = 0, cfg_o = CFG_RST, shadows = CFG_RST.
  - cfg_upd_o = 0, locked_o = 0.
  - CTRL = 0, ERR = 0, sticky = 0.
- Write: takes effect at the edge where writeEn=1. Register contents are visible on the following cycle.
- dataOut <= mux(addr) every edge, giving one-cycle read latency. The edge at which readEn clears a status register also loads the pre-clear value into dataOut.
- COMMIT write at edge N: cfg_o updates at N, and cfg_upd_o is high from N to N+1.
- AUTO config write at edge N: same pulse timing as COMMIT. Writes under AUTO=0 produce no pulse.
- Back-to-back writes every cycle are supported, with no stall.
- rst overrides writeEn and readEn in the same cycle. Reset mid-transaction discards the write.
- ERR write clear and an error event cannot coincide (single port).

## Structure
- Package i2c_reg_pkg holds:
  - ADDR_ID = 8'h00, ADDR_ERR = 8'h7E, ADDR_CTRL = 8'h7F;
  - CTRL bit indices CTRL_COMMIT = 0, CTRL_LOCK = 1, CTRL_AUTO = 2;
  - default ID_VALUE.
- Sub-module i2c_sticky_reg: one DATA_W sticky register with set vector and clear strobe, set-wins priority. Instantiated NUM_STAT times via generate.

## Test plan
- Reset, then read 0x00, 0x01, 0x7F, 0x7E -> 0x66, CFG_RST[7:0], 0x00, 0x00; cfg_o = CFG_RST.
- Write 0x01 = 0xA5 with AUTO=0 -> readback 0xA5, cfg_o[7:0] unchanged, no pulse. Write 0x7F = 0x01 -> cfg_o[7:0] = 0xA5 and one cfg_upd_o pulse.
- Write 0x7F = 0x04, then 0x02 = 0x3C -> cfg_o[15:8] = 0x3C next cycle with a pulse; CTRL reads 0x04.
- Write 0x7F = 0x02, then 0x03 = 0xFF -> shadow unchanged, ERR = 1, locked_o = 1. Write 0x7F = 0x00 -> still locked. Assert rst -> unlocked.
- Pulse stat_i[3:0] = 0x9 for one cycle -> 0x40 reads 0x09. readEn at 0x40 with stat_i bit1 set in the same cycle -> dataOut 0x09, next read 0x02.
- 300 writes to 0x50 -> ERR saturates at 0xFF. Write 0x7E -> ERR = 0.

Source files
------------

// File: rtl/i2c_reg_pkg.sv
// Shared constants for the I2C configuration/status register bank:
// fixed addresses, CTRL bit positions and the default ID byte.
package i2c_reg_pkg;

  localparam logic [7:0] ADDR_ID   = 8'h00;
  localparam logic [7:0] ADDR_ERR  = 8'h7E;
  localparam logic [7:0] ADDR_CTRL = 8'h7F;

  localparam int CTRL_COMMIT = 0;
  localparam int CTRL_LOCK   = 1;
  localparam int CTRL_AUTO   = 2;

  localparam logic [7:0] ID_VALUE_DEF = 8'h66;

endpackage

// File: rtl/i2c_sticky_reg.sv
// One sticky status register: event bits accumulate until a clear strobe,
// and an event arriving in the same cycle as the clear is kept.
module i2c_sticky_reg #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] set_i,
  input  logic              clr_i,
  output logic [DATA_W-1:0] q_o
);

  // Accumulate events; clear drops old bits but new events still land
  always_ff @(posedge clk) begin
    if (rst) begin
      q_o <= '0;
    end else begin
      q_o <= (q_o & ~{DATA_W{clr_i}}) | set_i;
    end
  end

endmodule

// File: rtl/i2c_reg_bank.sv
// Register bank behind the I2C slave byte interface: staged config
// registers with commit/auto-commit, clear-on-read sticky status, a
// one-way write-protect lock and a saturating illegal-write counter.
module i2c_reg_bank
  import i2c_reg_pkg::*;
#(
  parameter int                        NUM_CFG   = 13,
  parameter int                        NUM_STAT  = 4,
  parameter int                        STAT_BASE = 8'h40,
  parameter int                        DATA_W    = 8,
  parameter int                        ADDR_W    = 8,
  parameter logic [DATA_W-1:0]         ID_VALUE  = DATA_W'(ID_VALUE_DEF),
  parameter logic [NUM_CFG*DATA_W-1:0] CFG_RST   = '0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [ADDR_W-1:0]           addr,
  input  logic [DATA_W-1:0]           dataIn,
  input  logic                        writeEn,
  input  logic                        readEn,
  output logic [DATA_W-1:0]           dataOut,
  output logic [NUM_CFG*DATA_W-1:0]   cfg_o,
  output logic                        cfg_upd_o,
  input  logic [NUM_STAT*DATA_W-1:0]  stat_i,
  output logic                        locked_o
);

  logic [NUM_CFG*DATA_W-1:0] shadow_q;
  logic [NUM_CFG*DATA_W-1:0] active_q;
  logic                      lock_q;
  logic                      auto_q;
  logic [7:0]                err_q;
  logic                      upd_q;
  logic [DATA_W-1:0]         sticky_q [NUM_STAT];

  logic              is_id, is_err, is_ctrl, is_cfg, is_stat, is_mapped;
  logic              cfg_wr_ok, commit, err_evt;
  logic [DATA_W-1:0] rd_data;

  // Address decode and read mux; status reads return the pre-clear value
  always_comb begin
    is_id   = (addr == ADDR_W'(ADDR_ID));
    is_err  = (addr == ADDR_W'(ADDR_ERR));
    is_ctrl = (addr == ADDR_W'(ADDR_CTRL));
    is_cfg  = 1'b0;
    is_stat = 1'b0;
    rd_data = '0;
    if (is_id)   rd_data = ID_VALUE;
    if (is_err)  rd_data = DATA_W'(err_q);
    if (is_ctrl) rd_data = DATA_W'({auto_q, lock_q, 1'b0});
    for (int k = 0; k < NUM_CFG; k++) begin
      if (addr == ADDR_W'(k + 1)) begin
        is_cfg  = 1'b1;
        rd_data = shadow_q[k*DATA_W +: DATA_W];
      end
    end
    for (int k = 0; k < NUM_STAT; k++) begin
      if (addr == ADDR_W'(STAT_BASE + k)) begin
        is_stat = 1'b1;
        rd_data = sticky_q[k];
      end
    end
    is_mapped = is_id | is_err | is_ctrl | is_cfg | is_stat;
    cfg_wr_ok = writeEn & is_cfg & ~lock_q;
    commit    = writeEn & is_ctrl & dataIn[CTRL_COMMIT];
    err_evt   = writeEn & (is_id | is_stat | (is_cfg & lock_q) | ~is_mapped);
  end

  // Config shadows, active copy, CTRL bits, error counter and read data
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_q <= CFG_RST;
      active_q <= CFG_RST;
      lock_q   <= 1'b0;
      auto_q   <= 1'b0;
      err_q    <= 8'h00;
      upd_q    <= 1'b0;
      dataOut  <= '0;
    end else begin
      upd_q   <= commit | (cfg_wr_ok & auto_q);
      dataOut <= rd_data;
      if (commit) begin
        active_q <= shadow_q;
      end
      for (int k = 0; k < NUM_CFG; k++) begin
        if (cfg_wr_ok && addr == ADDR_W'(k + 1)) begin
          shadow_q[k*DATA_W +: DATA_W] <= dataIn;
          if (auto_q) begin
            active_q[k*DATA_W +: DATA_W] <= dataIn;
          end
        end
      end
      if (writeEn && is_ctrl && !lock_q) begin
        lock_q <= dataIn[CTRL_LOCK];
        auto_q <= dataIn[CTRL_AUTO];
      end
      if (writeEn && is_err) begin
        err_q <= 8'h00;
      end else if (err_evt && err_q != 8'hFF) begin
        err_q <= err_q + 8'h01;
      end
    end
  end

  // One sticky register per status address, cleared when its byte is consumed
  for (genvar g = 0; g < NUM_STAT; g++) begin : g_stat
    i2c_sticky_reg #(.DATA_W(DATA_W)) u_sticky (
      .clk   (clk),
      .rst   (rst),
      .set_i (stat_i[g*DATA_W +: DATA_W]),
      .clr_i (readEn && addr == ADDR_W'(STAT_BASE + g)),
      .q_o   (sticky_q[g])
    );
  end

  assign cfg_o     = active_q;
  assign cfg_upd_o = upd_q;
  assign locked_o  = lock_q;

endmodule

// File: tb/tb_i2c_reg_bank.sv
// Self-checking bench for i2c_reg_bank: directed walk through the main
// features with literal expectations, then randomized traffic compared
// every cycle against a behavioural register-map model.
module tb_i2c_reg_bank;

  localparam int NC = 13;
  localparam int NS = 4;

  logic          clk;
  logic          rst;
  logic [7:0]    addr;
  logic [7:0]    dataIn;
  logic          writeEn;
  logic          readEn;
  logic [7:0]    dataOut;
  logic [NC*8-1:0] cfg_o;
  logic          cfg_upd_o;
  logic [NS*8-1:0] stat_i;
  logic          locked_o;

  int checks = 0;
  int errors = 0;

  i2c_reg_bank dut (
    .clk       (clk),
    .rst       (rst),
    .addr      (addr),
    .dataIn    (dataIn),
    .writeEn   (writeEn),
    .readEn    (readEn),
    .dataOut   (dataOut),
    .cfg_o     (cfg_o),
    .cfg_upd_o (cfg_upd_o),
    .stat_i    (stat_i),
    .locked_o  (locked_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model state: plain arrays indexed by register number
  logic [7:0] m_shadow [NC];
  logic [7:0] m_active [NC];
  logic [7:0] m_sticky [NS];
  logic       m_lock, m_auto, m_upd;
  int         m_err;
  logic [7:0] m_dout;
  bit         m_valid = 0;

  function automatic logic [7:0] modelRead(input logic [7:0] a);
    if (a == 8'h00) return 8'h66;
    if (a >= 8'h01 && a <= 8'(NC)) return m_shadow[int'(a) - 1];
    if (a >= 8'h40 && a < 8'(8'h40 + NS)) return m_sticky[int'(a) - 8'h40];
    if (a == 8'h7E) return 8'(m_err);
    if (a == 8'h7F) return {5'b0, m_auto, m_lock, 1'b0};
    return 8'h00;
  endfunction

  // Model advances once per rising edge from the inputs held across it
  initial begin
    forever begin
      @(posedge clk);
      if (rst) begin
        for (int k = 0; k < NC; k++) begin
          m_shadow[k] = 8'h00;
          m_active[k] = 8'h00;
        end
        for (int k = 0; k < NS; k++) m_sticky[k] = 8'h00;
        m_lock = 0; m_auto = 0; m_upd = 0; m_err = 0; m_dout = 8'h00;
        m_valid = 1;
      end else begin
        logic [7:0] rd;
        int a;
        rd = modelRead(addr);
        a = int'(addr);
        for (int k = 0; k < NS; k++)
          m_sticky[k] = ((readEn && a == 8'h40 + k) ? 8'h00 : m_sticky[k]) | stat_i[k*8 +: 8];
        m_upd = 0;
        if (writeEn) begin
          if (a >= 1 && a <= NC) begin
            if (m_lock) begin
              if (m_err < 255) m_err++;
            end else begin
              m_shadow[a-1] = dataIn;
              if (m_auto) begin
                m_active[a-1] = dataIn;
                m_upd = 1;
              end
            end
          end else if (a == 8'h7E) begin
            m_err = 0;
          end else if (a == 8'h7F) begin
            if (dataIn[0]) begin
              for (int k = 0; k < NC; k++) m_active[k] = m_shadow[k];
              m_upd = 1;
            end
            if (!m_lock) begin
              m_lock = dataIn[1];
              m_auto = dataIn[2];
            end
          end else begin
            if (m_err < 255) m_err++;
          end
        end
        m_dout = rd;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Every settled cycle the outputs must match the model
  always @(negedge clk) begin
    if (m_valid) begin
      logic [NC*8-1:0] exp_cfg;
      for (int k = 0; k < NC; k++) exp_cfg[k*8 +: 8] = m_active[k];
      checkOutput("model dataOut", 128'(dataOut), 128'(m_dout));
      checkOutput("model cfg_o", 128'(cfg_o), 128'(exp_cfg));
      checkOutput("model cfg_upd_o", 128'(cfg_upd_o), 128'(m_upd));
      checkOutput("model locked_o", 128'(locked_o), 128'(m_lock));
    end
  end

  // Hold one set of inputs across exactly one rising edge
  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] d,
                               input logic we, input logic re, input logic [NS*8-1:0] st);
    addr = a; dataIn = d; writeEn = we; readEn = re; stat_i = st;
    @(negedge clk);
  endtask

  task automatic writeReg(input logic [7:0] a, input logic [7:0] d);
    applyStimulus(a, d, 1'b1, 1'b0, '0);
  endtask

  task automatic readCheck(input string name, input logic [7:0] a, input logic [7:0] exp);
    applyStimulus(a, 8'h00, 1'b0, 1'b0, '0);
    checkOutput(name, 128'(dataOut), 128'(exp));
  endtask

  initial begin
    rst = 1'b1; addr = 8'h00; dataIn = 8'h00; writeEn = 0; readEn = 0; stat_i = '0;
    repeat (2) @(negedge clk);
    checkOutput("reset dataOut", 128'(dataOut), 128'h0);
    checkOutput("reset cfg_o", 128'(cfg_o), 128'h0);
    checkOutput("reset locked", 128'(locked_o), 128'h0);
    rst = 1'b0;

    readCheck("read ID", 8'h00, 8'h66);
    readCheck("read cfg1 reset", 8'h01, 8'h00);
    readCheck("read CTRL reset", 8'h7F, 8'h00);
    readCheck("read ERR reset", 8'h7E, 8'h00);

    writeReg(8'h01, 8'hA5);
    checkOutput("no pulse AUTO=0", 128'(cfg_upd_o), 128'h0);
    readCheck("shadow readback", 8'h01, 8'hA5);
    checkOutput("cfg0 before commit", 128'(cfg_o[7:0]), 128'h00);
    writeReg(8'h7F, 8'h01);
    checkOutput("cfg0 after commit", 128'(cfg_o[7:0]), 128'hA5);
    checkOutput("commit pulse", 128'(cfg_upd_o), 128'h1);
    readCheck("CTRL commit reads 0", 8'h7F, 8'h00);
    checkOutput("pulse one cycle", 128'(cfg_upd_o), 128'h0);

    writeReg(8'h7F, 8'h04);
    writeReg(8'h02, 8'h3C);
    checkOutput("auto cfg1", 128'(cfg_o[15:8]), 128'h3C);
    checkOutput("auto pulse", 128'(cfg_upd_o), 128'h1);
    readCheck("CTRL auto", 8'h7F, 8'h04);

    writeReg(8'h7F, 8'h02);
    checkOutput("lock set", 128'(locked_o), 128'h1);
    writeReg(8'h03, 8'hFF);
    readCheck("locked shadow kept", 8'h03, 8'h00);
    readCheck("locked write err", 8'h7E, 8'h01);
    writeReg(8'h7F, 8'h00);
    checkOutput("lock sticks", 128'(locked_o), 128'h1);
    readCheck("CTRL frozen", 8'h7F, 8'h02);
    readCheck("CTRL write no err", 8'h7E, 8'h01);
    rst = 1'b1;
    applyStimulus(8'h03, 8'h77, 1'b1, 1'b0, '0);
    rst = 1'b0;
    checkOutput("reset unlocks", 128'(locked_o), 128'h0);
    readCheck("reset drops write", 8'h03, 8'h00);

    applyStimulus(8'h00, 8'h00, 1'b0, 1'b0, 32'h0000_0009);
    readCheck("sticky set", 8'h40, 8'h09);
    applyStimulus(8'h40, 8'h00, 1'b0, 1'b1, 32'h0000_0002);
    checkOutput("sticky pre-clear", 128'(dataOut), 128'h09);
    readCheck("sticky set wins", 8'h40, 8'h02);

    for (int i = 0; i < 300; i++) writeReg(8'h50, 8'h11);
    readCheck("err saturates", 8'h7E, 8'hFF);
    writeReg(8'h7E, 8'h5A);
    readCheck("err cleared", 8'h7E, 8'h00);

    // Randomized traffic biased toward interesting addresses
    for (int i = 0; i < 3000; i++) begin
      logic [7:0] a;
      logic [7:0] d;
      case ($urandom_range(0, 7))
        0: a = 8'h00;
        1, 2: a = 8'($urandom_range(1, NC + 1));
        3: a = 8'($urandom_range(8'h3F, 8'h44));
        4: a = 8'h7E;
        5: a = ($urandom_range(0, 3) == 0) ? 8'h7F : 8'($urandom_range(1, NC));
        default: a = 8'($urandom);
      endcase
      d = 8'($urandom);
      if (a == 8'h7F && $urandom_range(0, 3) != 0) d[1] = 1'b0;
      rst = ($urandom_range(0, 199) == 0);
      applyStimulus(a, d, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    ($urandom_range(0, 5) == 0) ? 32'($urandom) & 32'h2418_8142 : '0);
    end
    rst = 1'b0;
    applyStimulus(8'h00, 8'h00, 1'b0, 1'b0, '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
